// File: rtl/spi_seg_arbiter_if.sv
// Request/response and SPI pin bundle for the two-requester SPI arbiter.
// slave = arbiter side, master = requesters plus the SPI target model.
interface spi_seg_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              ss;
    logic              sck;
    logic              mosi;
    logic              miso;

    modport slave (
        input  req0, req1, data0, data1, miso,
        output done0, done1, rx_data, busy, ss, sck, mosi
    );

    modport master (
        output req0, req1, data0, data1, miso,
        input  done0, done1, rx_data, busy, ss, sck, mosi
    );
endinterface

// File: rtl/spi_seg_arbiter.sv
// Round-robin arbiter for two requesters sharing one SPI mode-0 link.
// Serialises MSB-first, captures miso, pulses the owner's done on completion.
module spi_seg_arbiter #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_seg_arbiter_if.slave bus
);
    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [1:0]        done_q, done_d;
    logic              ss_q, ss_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;

    logic [1:0]             req;
    logic [1:0][DATA_W-1:0] data;
    logic                   hc_end;

    assign req    = {bus.req1, bus.req0};
    assign data   = {bus.data1, bus.data0};
    assign hc_end = (hc_q == HC_LAST);

    always_comb begin
        state_d   = state_q;
        hc_d      = (state_q == S_IDLE || hc_end) ? '0 : hc_q + 1'b1;
        bc_d      = bc_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        owner_d   = owner_q;
        last_d    = last_q;
        done_d    = '0;
        ss_d      = ss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // On a tie the requester not served last wins.
                    owner_d = (&req) ? ~last_q : req[1];
                    tx_d    = data[owner_d];
                    mosi_d  = tx_d[DATA_W-1];
                    rx_sh_d = '0;
                    bc_d    = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (hc_end) begin
                    sck_d   = 1'b1;
                    rx_sh_d = (rx_sh_q << 1) | DATA_W'(bus.miso);
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (hc_end) begin
                    sck_d = 1'b0;
                    if (bc_q == BC_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        tx_d    = tx_q << 1;
                        mosi_d  = tx_d[DATA_W-1];
                        bc_d    = bc_q + 1'b1;
                        state_d = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (hc_end) begin
                    ss_d            = 1'b1;
                    rx_data_d       = rx_sh_q;
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = S_GAP;
                end
            end
            S_GAP: begin
                // Keeps ss high for a minimum time before the next grant.
                if (hc_end) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ss_d    = 1'b1;
                sck_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hc_q      <= '0;
            bc_q      <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            done_q    <= '0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            bc_q      <= bc_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            done_q    <= done_d;
            ss_q      <= ss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rx_data = rx_data_q;
    assign bus.busy    = busy_q;
    assign bus.ss      = ss_q;
    assign bus.sck     = sck_q;
    assign bus.mosi    = mosi_q;
endmodule

// File: tb/tb_spi_seg_arbiter.sv
// Bench for spi_seg_arbiter: frame monitor plus a round-robin/serialisation
// reference model, random and directed scenarios, DATA_W=8, CLK_DIV=2.
module tb_spi_seg_arbiter;
    localparam int DW     = 8;
    localparam int CD     = 2;
    localparam int SS_LOW = (2 * DW + 1) * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_seg_arbiter_if #(.DATA_W(DW)) bus ();
    spi_seg_arbiter #(.DATA_W(DW), .CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(bus));

    // SPI target model: loopback or a fixed byte shifted out while sck is low.
    bit         loop_mode = 1'b1;
    logic [7:0] pat_byte  = 8'h00;
    logic       pat_bit   = 1'b0;
    always_comb bus.miso = loop_mode ? bus.mosi : pat_bit;

    typedef struct {
        int         owner;
        int         ss_len;
        int         rises;
        logic [7:0] mosi_b;
        logic [7:0] miso_b;
        logic [7:0] rx;
        bit         mosi_any;
    } frame_t;

    frame_t     frames[$];
    frame_t     mon_f;
    int         ss_len = 0, rises = 0, dcnt0 = 0, dcnt1 = 0, longp = 0;
    logic [7:0] mosi_sh = 8'h00, miso_sh = 8'h00;
    bit         mosi_any = 1'b0, sck_prev = 1'b0, d0_prev = 1'b0, d1_prev = 1'b0;
    bit         last_srv = 1'b1;

    always @(negedge clk) begin
        if (bus.done0 || bus.done1) begin
            mon_f.owner    = bus.done1 ? 1 : 0;
            mon_f.ss_len   = ss_len;
            mon_f.rises    = rises;
            mon_f.mosi_b   = mosi_sh;
            mon_f.miso_b   = miso_sh;
            mon_f.rx       = bus.rx_data;
            mon_f.mosi_any = mosi_any;
            frames.push_back(mon_f);
        end
        dcnt0 <= dcnt0 + (bus.done0 ? 1 : 0);
        dcnt1 <= dcnt1 + (bus.done1 ? 1 : 0);
        if ((bus.done0 && d0_prev) || (bus.done1 && d1_prev)) longp <= longp + 1;
        d0_prev  <= bus.done0;
        d1_prev  <= bus.done1;
        sck_prev <= bus.sck;
        if (bus.ss) begin
            ss_len   <= 0;
            rises    <= 0;
            mosi_sh  <= 8'h00;
            miso_sh  <= 8'h00;
            mosi_any <= 1'b0;
        end else begin
            ss_len <= ss_len + 1;
            if (bus.mosi) mosi_any <= 1'b1;
            if (bus.sck && !sck_prev) begin
                rises   <= rises + 1;
                mosi_sh <= {mosi_sh[6:0], bus.mosi};
                miso_sh <= {miso_sh[6:0], bus.miso};
            end
        end
        if (!bus.sck) pat_bit <= (rises < 8) ? pat_byte[3'(7 - rises)] : 1'b0;
    end

    // Requester behaviour: hold req until own done, then drop it.
    task automatic serve(input bit a0, input bit a1, input logic [7:0] d0,
                         input logic [7:0] d1, output int lat, output bit tmo);
        int cyc;
        bit p0, p1;
        tmo = 1'b0;
        lat = -1;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (bus.busy) tmo = 1'b1;
        p0 = a0;
        p1 = a1;
        bus.data0 = d0;
        bus.data1 = d1;
        bus.req0  = a0;
        bus.req1  = a1;
        cyc = 0;
        while ((p0 || p1) && !tmo) begin
            @(negedge clk);
            cyc++;
            if (bus.done0 && p0) begin bus.req0 = 1'b0; p0 = 1'b0; if (lat < 0) lat = cyc; end
            if (bus.done1 && p1) begin bus.req1 = 1'b0; p1 = 1'b0; if (lat < 0) lat = cyc; end
            if (cyc > 400) tmo = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_srv = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = '0; bus.data1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ss !== 1'b1) begin errors++; $display("FAIL reset_ss got %b exp 1", bus.ss); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b exp 0", bus.sck); end
        checks++; if (bus.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", bus.mosi); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if ({bus.done1, bus.done0} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {bus.done1, bus.done0}); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got %h exp 00", bus.rx_data); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.ss !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset ss=%b busy=%b exp 1/0", bus.ss, bus.busy); end
    endtask

    task automatic test_single_frame();
        int lat, c1;
        bit tmo;
        frames.delete();
        loop_mode = 1'b1;
        c1 = dcnt1;
        serve(1'b1, 1'b0, 8'hA5, 8'h00, lat, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL single_timeout got timeout exp done0"); end
        checks++; if (lat !== 1 + SS_LOW) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, 1 + SS_LOW); end
        checks++; if (frames.size() !== 1) begin errors++; $display("FAIL single_frames got %0d exp 1", frames.size()); end
        if (frames.size() > 0) begin
            checks++; if (frames[0].owner !== 0) begin errors++; $display("FAIL single_owner got %0d exp 0", frames[0].owner); end
            checks++; if (frames[0].rises !== 8) begin errors++; $display("FAIL single_rises got %0d exp 8", frames[0].rises); end
            checks++; if (frames[0].ss_len !== SS_LOW) begin errors++; $display("FAIL single_ss_len got %0d exp %0d", frames[0].ss_len, SS_LOW); end
            checks++; if (frames[0].mosi_b !== 8'hA5) begin errors++; $display("FAIL single_mosi got %h exp a5", frames[0].mosi_b); end
            checks++; if (frames[0].rx !== 8'hA5) begin errors++; $display("FAIL single_rx got %h exp a5", frames[0].rx); end
        end
        checks++; if (dcnt1 !== c1) begin errors++; $display("FAIL single_done1 got %0d exp %0d", dcnt1, c1); end
        checks++; if (longp !== 0) begin errors++; $display("FAIL single_done_width got %0d long pulses exp 0", longp); end
        last_srv = 1'b0;
    endtask

    task automatic test_capture();
        int lat, c1;
        bit tmo;
        frames.delete();
        loop_mode = 1'b0;
        pat_byte  = 8'h3C;
        c1 = dcnt1;
        serve(1'b0, 1'b1, 8'h00, 8'h00, lat, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL capture_timeout got timeout exp done1"); end
        checks++; if (frames.size() !== 1) begin errors++; $display("FAIL capture_frames got %0d exp 1", frames.size()); end
        if (frames.size() > 0) begin
            checks++; if (frames[0].owner !== 1) begin errors++; $display("FAIL capture_owner got %0d exp 1", frames[0].owner); end
            checks++; if (frames[0].rx !== 8'h3C) begin errors++; $display("FAIL capture_rx got %h exp 3c", frames[0].rx); end
            checks++; if (frames[0].mosi_any !== 1'b0) begin errors++; $display("FAIL capture_mosi got %b exp 0", frames[0].mosi_any); end
        end
        checks++; if (dcnt1 !== c1 + 1) begin errors++; $display("FAIL capture_done1 got %0d exp %0d", dcnt1, c1 + 1); end
        loop_mode = 1'b1;
        last_srv  = 1'b1;
    endtask

    task automatic test_arbitration();
        int  lat;
        bit  tmo;
        int  exp_own[$];
        bit  a0s[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        frames.delete();
        for (int s = 0; s < 4; s++) begin
            int first;
            first = a0s[s] ? (last_srv ? 0 : 1) : 1;
            exp_own.push_back(first);
            if (a0s[s]) exp_own.push_back(1 - first);
            last_srv = exp_own[exp_own.size() - 1] != 0;
            serve(a0s[s], 1'b1, 8'($urandom), 8'($urandom), lat, tmo);
            checks++; if (tmo) begin errors++; $display("FAIL arb_timeout step %0d", s); end
        end
        checks++; if (frames.size() !== exp_own.size()) begin errors++; $display("FAIL arb_frames got %0d exp %0d", frames.size(), exp_own.size()); end
        for (int k = 0; k < exp_own.size() && k < frames.size(); k++) begin
            checks++; if (frames[k].owner !== exp_own[k]) begin errors++; $display("FAIL arb_owner[%0d] got %0d exp %0d", k, frames[k].owner, exp_own[k]); end
        end
    endtask

    task automatic test_spacing();
        logic [7:0] da, db;
        int cyc, ss_hi, busy_lo;
        frames.delete();
        loop_mode = 1'b1;
        da = 8'($urandom);
        db = 8'($urandom);
        bus.data0 = da;
        bus.req0  = 1'b1;
        cyc = 0;
        while (!bus.done0 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (!bus.done0) begin errors++; $display("FAIL spacing_first_done got timeout exp done0"); end
        bus.data0 = db;
        ss_hi = 0; busy_lo = 0; cyc = 0;
        while (bus.ss && cyc < 200) begin
            ss_hi++;
            if (!bus.busy) busy_lo++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (ss_hi < CD + 1) begin errors++; $display("FAIL spacing_ss_high got %0d exp >= %0d", ss_hi, CD + 1); end
        checks++; if (busy_lo !== 1) begin errors++; $display("FAIL spacing_busy_low got %0d exp 1", busy_lo); end
        cyc = 0;
        while (!bus.done0 && cyc < 200) begin @(negedge clk); cyc++; end
        bus.req0 = 1'b0;
        #1;
        checks++; if (frames.size() !== 2) begin errors++; $display("FAIL spacing_frames got %0d exp 2", frames.size()); end
        if (frames.size() == 2) begin
            checks++; if (frames[0].mosi_b !== da) begin errors++; $display("FAIL spacing_byte0 got %h exp %h", frames[0].mosi_b, da); end
            checks++; if (frames[1].mosi_b !== db) begin errors++; $display("FAIL spacing_byte1 got %h exp %h", frames[1].mosi_b, db); end
        end
        last_srv = 1'b0;
    endtask

    task automatic test_withdraw();
        int cyc, c1, busy_hi;
        frames.delete();
        c1 = dcnt1;
        bus.data0 = 8'($urandom);
        bus.req0  = 1'b1;
        cyc = 0;
        while (bus.ss && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        bus.req1 = 1'b1;
        @(negedge clk);
        bus.req1 = 1'b0;
        cyc = 0;
        while (!bus.done0 && cyc < 200) begin @(negedge clk); cyc++; end
        bus.req0 = 1'b0;
        repeat (CD + 2) @(negedge clk);
        busy_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy || !bus.ss) busy_hi++;
            @(negedge clk);
        end
        checks++; if (busy_hi !== 0) begin errors++; $display("FAIL withdraw_idle got %0d busy cycles exp 0", busy_hi); end
        checks++; if (dcnt1 !== c1) begin errors++; $display("FAIL withdraw_done1 got %0d exp %0d", dcnt1, c1); end
        checks++; if (frames.size() !== 1) begin errors++; $display("FAIL withdraw_frames got %0d exp 1", frames.size()); end
        last_srv = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int cyc, c0, c1, lat;
        bit tmo;
        loop_mode = 1'b1;
        bus.data0 = 8'($urandom);
        bus.req0  = 1'b1;
        cyc = 0;
        while (!(rises == 5 && bus.sck) && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (rises !== 5) begin errors++; $display("FAIL midreset_reach got %0d rises exp 5", rises); end
        c0 = dcnt0; c1 = dcnt1;
        frames.delete();
        rst = 1'b1;
        #1;
        checks++; if (bus.ss !== 1'b1) begin errors++; $display("FAIL midreset_ss got %b exp 1", bus.ss); end
        checks++; if (bus.sck !== 1'b0) begin errors++; $display("FAIL midreset_sck got %b exp 0", bus.sck); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx got %h exp 00", bus.rx_data); end
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_srv = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (dcnt0 !== c0 || dcnt1 !== c1 || frames.size() !== 0) begin errors++; $display("FAIL midreset_no_done got %0d/%0d exp %0d/%0d", dcnt0, dcnt1, c0, c1); end
        serve(1'b0, 1'b1, 8'h00, 8'h81, lat, tmo);
        checks++; if (tmo || frames.size() !== 1) begin errors++; $display("FAIL midreset_fresh got %0d frames exp 1", frames.size()); end
        if (frames.size() > 0) begin
            checks++; if (frames[0].owner !== 1 || frames[0].rx !== 8'h81) begin errors++; $display("FAIL midreset_fresh_rx got owner %0d rx %h exp 1 81", frames[0].owner, frames[0].rx); end
        end
        last_srv = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int         c, n, lat, first;
            int         own[2];
            bit         a0, a1, tmo;
            logic [7:0] d0, d1, ed, er;
            c  = $urandom_range(1, 3);
            a0 = c[0];
            a1 = c[1];
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            loop_mode = $urandom_range(0, 1) != 0;
            pat_byte  = 8'($urandom);
            n      = (a0 && a1) ? 2 : 1;
            first  = (a0 && a1) ? (last_srv ? 0 : 1) : (a1 ? 1 : 0);
            own[0] = first;
            own[1] = 1 - first;
            frames.delete();
            serve(a0, a1, d0, d1, lat, tmo);
            checks++; if (tmo || frames.size() !== n) begin errors++; $display("FAIL rnd%0d_frames got %0d exp %0d", it, frames.size(), n); end
            for (int k = 0; k < n && k < frames.size(); k++) begin
                ed = own[k] ? d1 : d0;
                er = loop_mode ? ed : pat_byte;
                checks++; if (frames[k].owner !== own[k]) begin errors++; $display("FAIL rnd%0d_owner got %0d exp %0d", it, frames[k].owner, own[k]); end
                checks++; if (frames[k].mosi_b !== ed) begin errors++; $display("FAIL rnd%0d_mosi got %h exp %h", it, frames[k].mosi_b, ed); end
                checks++; if (frames[k].rx !== er) begin errors++; $display("FAIL rnd%0d_rx got %h exp %h", it, frames[k].rx, er); end
                checks++; if (frames[k].ss_len !== SS_LOW || frames[k].rises !== 8) begin errors++; $display("FAIL rnd%0d_timing got %0d/%0d exp %0d/8", it, frames[k].ss_len, frames[k].rises, SS_LOW); end
            end
            last_srv = own[n-1] != 0;
        end
        checks++; if (longp !== 0) begin errors++; $display("FAIL rnd_done_width got %0d long pulses exp 0", longp); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_capture();
        test_arbitration();
        test_spacing();
        test_withdraw();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_seg_arbiter.md
# spi_seg_arbiter

Two-requester SPI master controller that shares a single SPI link to the seven-segment SPI slave (the `ss`/`sck`/`mosi`/`miso` display target).
- It arbitrates round-robin between two local requesters.
- It serialises the granted 8-bit byte MSB-first in SPI mode 0, captures the byte returned on `miso`, and reports completion to the owning requester.
- It sits between the system-clock fabric and the display SPI pins, so no other block drives those pins.

## Interface
Parameters:
- `DATA_W`, default 8: bits per transfer; supported range 1..16.
- `CLK_DIV`, default 4: system clock cycles per `sck` half-period; must be at least 1.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 transfer request; level, held until `done0`.
- `data0`  in  DATA_W  requester 0 transmit byte; sampled at grant.
- `done0`  out  1  one-cycle pulse when requester 0's transfer completes.
- `req1`, `data1`, `done1`: same meaning, for requester 1.
- `rx_data`  out  DATA_W  byte captured from `miso` during the last completed transfer.
- `busy`  out  1  high from the grant cycle through the end of the GAP state.
- `ss`  out  1  slave select, active low.
- `sck`  out  1  SPI clock; idles low.
- `mosi`  out  1  master data out.
- `miso`  in  1  slave data in; assumed already synchronous to `clk` (the slave is driven from the same domain).

## Operation
States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- Half-period counter `hc` counts 0..CLK_DIV-1. It resets to 0 on every state entry.
- Bit counter `bc` counts 0..DATA_W-1.

IDLE:
- Outputs: `ss`=1, `sck`=0, `busy`=0.
- If any `req` is high, grant it:
  - Only one requester asserted: that requester wins.
  - Both asserted: the requester not served last wins. The last-served pointer resets to 1, so req0 wins the first tie.
- Grant cycle actions: latch `data` into the shift register, record the owner, go to SETUP.

SETUP (CLK_DIV cycles):
- `ss`=0, `mosi`=shift MSB, `sck`=0.
- Then go to HIGH.

HIGH (CLK_DIV cycles):
- `sck`=1.
- On entry, shift `miso` into the receive shift register LSB.
- At the end of the state:
  - If `bc`=DATA_W-1, go to HOLD.
  - Otherwise go to LOW.

LOW (CLK_DIV cycles):
- `sck`=0.
- On entry, shift the transmit register left and drive the next bit on `mosi`; `bc` increments.
- Then go to HIGH.

HOLD (CLK_DIV cycles):
- `sck`=0, `ss`=0.
- On exit:
  - Raise `ss`.
  - Update `rx_data`.
  - Pulse the owner's `done` for exactly one cycle.
  - Update the last-served pointer.
  - Go to GAP.

GAP (CLK_DIV cycles):
- `ss`=1, `busy`=1.
- Then go to IDLE. This guarantees a minimum `ss`-high time between frames.

Requester rules:
- `req` dropping before grant withdraws the request.
- After grant, `req` and `data` are ignored until `done`.
- A requester must see its `done` before it reasserts `req` for a new byte. If `req` is still high in the cycle after `done`, that is treated as a new request.

Reset (asynchronous, any state):
- State goes to IDLE.
- `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `done0`=`done1`=0, `rx_data`=0.
- Last-served pointer resets to 1 (so req0 wins the first tie). Shift registers and counters reset to 0.
- An aborted transfer produces no `done`.

## Timing
- Grant is registered: `req` high at edge N gives `ss`=0 and `busy`=1 after edge N+1.
- First `sck` rise occurs CLK_DIV cycles after `ss` falls, so `mosi` is stable for a full half-period before every rising edge.
- `ss` low duration: (2*DATA_W + 1)*CLK_DIV cycles, which is 68 for the defaults.
- Request-to-`done` latency: 1 + (2*DATA_W + 1)*CLK_DIV cycles. `done` is asserted in the first cycle with `ss`=1.
- Minimum `ss` high between frames: CLK_DIV + 1 cycles (GAP plus the IDLE grant cycle).
- `rx_data` is valid from the `done` cycle and holds until the next `done`.
- All outputs are registered; no combinational path from `miso` or `req` to any output.

## Test plan
- Single frame, CLK_DIV=2: req0=1 with data0=8'hA5 and `miso` looped to `mosi`.
  - Expect 8 `sck` rising edges; `ss` low for exactly 34 cycles.
  - Expect `mosi` bits sampled on the rising edges to be 1,0,1,0,0,1,0,1.
  - Expect `done0` for one cycle with `rx_data`=8'hA5; `done1` stays 0.
- Capture independent of transmit: data1=8'h00, `miso` driven as 8'h3C (one bit per LOW state).
  - Expect `rx_data`=8'h3C at `done1`, and `mosi`=0 throughout the frame.
- Arbitration sequence:
  - req0 and req1 asserted in the same cycle after reset: expect req0 served first, then req1.
  - Both asserted again: expect req0 first again (alternation).
  - req1 alone repeated twice: expect req1 to be granted both times.
- Inter-frame spacing: req0 held continuously for two bytes (reasserted after `done0`).
  - Expect `ss` high for at least CLK_DIV+1 cycles between frames.
  - Expect `busy` to drop for exactly one cycle in between.
- Reset mid-frame: assert `rst` during bit 4 HIGH.
  - Expect `ss`=1, `sck`=0, `busy`=0 and `rx_data`=0 immediately, with no `done` pulse.
  - After release, a fresh req1 with 8'h81 completes normally.
- Withdrawn request: req1 pulsed for one cycle while a req0 frame is in progress.
  - Expect no req1 grant and no `done1`; the bus returns to IDLE after the req0 GAP.
